alien_shoot_poller: RTL and testbench

Avalon-MM read initiator that polls the single-bit "alien shoot" input PIO slave on a fixed period. It debounces the sampled bit over consecutive polls and produces a clean level, a one-cycle rising-edge event and an event count. It sits between the interconnect master port and the game logic, so the game can react to shots without Nios software polling.

---
 rtl/alien_poll_pkg.sv | 22 ++
 rtl/alien_shoot_poller_if.sv | 23 ++
 rtl/alien_shoot_poller_sample_debounce.sv | 57 +++++
 rtl/alien_shoot_poller.sv | 117 +++++++++++
 tb/tb_alien_shoot_poller.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/alien_poll_pkg.sv
// rtl/alien_poll_pkg.sv - shared state type, address and parameter defaults for the shoot poller
package alien_poll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2
  } poll_state_e;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  localparam int DEF_POLL_PERIOD    = 8;
  localparam int DEF_READ_LATENCY   = 1;
  localparam int DEF_DEBOUNCE_COUNT = 3;
  localparam int DEF_CNT_W          = 16;

  // Width of a down/up counter whose largest value is n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alien_shoot_poller_if.sv
// rtl/alien_shoot_poller_if.sv - Avalon-MM read-only master/slave bundle used by the shoot poller
interface alien_shoot_poller_if;

  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );

endinterface

// File: rtl/alien_shoot_poller_sample_debounce.sv
// rtl/alien_shoot_poller_sample_debounce.sv - debounces one bit sampled once per poll
// Level flips only after DEBOUNCE_COUNT consecutive samples disagree with it.
module sample_debounce
  import alien_poll_pkg::*;
#(
  parameter  int DEBOUNCE_COUNT = DEF_DEBOUNCE_COUNT,
  localparam int SW             = cnt_width(DEBOUNCE_COUNT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_valid,
  input  logic          sample,
  output logic          level,
  output logic          rise_pulse,
  output logic [SW-1:0] stable_cnt
);

  localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE_COUNT - 1);

  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [SW-1:0] stable_q, stable_d;

  always_comb begin
    level_d  = level_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    if (sample_valid) begin
      if (sample == level_q) begin
        stable_d = '0;
      end else if (stable_q == STABLE_LAST) begin
        level_d  = sample;
        stable_d = '0;
        rise_d   = sample;
      end else begin
        stable_d = stable_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      stable_q <= '0;
    end else begin
      level_q  <= level_d;
      rise_q   <= rise_d;
      stable_q <= stable_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;
  assign stable_cnt = stable_q;

endmodule

// File: rtl/alien_shoot_poller.sv
// rtl/alien_shoot_poller.sv - periodic Avalon-MM poller of the alien shoot PIO bit
// Reads the PIO data register every poll, debounces bit 0 and counts rising edges.
module alien_shoot_poller
  import alien_poll_pkg::*;
#(
  parameter int POLL_PERIOD    = DEF_POLL_PERIOD,
  parameter int READ_LATENCY   = DEF_READ_LATENCY,
  parameter int DEBOUNCE_COUNT = DEF_DEBOUNCE_COUNT,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  alien_shoot_poller_if.master  avm,
  output logic                  shoot_level,
  output logic                  shoot_event,
  output logic [CNT_W-1:0]      shoot_count
);

  localparam int PW = cnt_width(POLL_PERIOD);
  localparam int LW = cnt_width(READ_LATENCY);
  localparam int SW = cnt_width(DEBOUNCE_COUNT);

  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_PERIOD - 1);
  localparam logic [LW-1:0] LAT_RELOAD  = LW'(READ_LATENCY - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE_COUNT - 1);

  poll_state_e      state_q, state_d;
  logic [PW-1:0]    poll_cnt_q, poll_cnt_d;
  logic [LW-1:0]    lat_cnt_q, lat_cnt_d;
  logic             read_q, read_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             sample_valid;
  logic             rise_edge;
  logic [SW-1:0]    stable_cnt;
  logic             unused_readdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      poll_cnt_q <= POLL_RELOAD;
      lat_cnt_q  <= '0;
      read_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      read_q     <= read_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && (poll_cnt_q == '0)) state_d = READ;
      READ:    if (!avm.avm_waitrequest)         state_d = WAIT;
      WAIT:    if (lat_cnt_q == '0)              state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    poll_cnt_d   = poll_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    sample_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (!enable) begin
          poll_cnt_d = POLL_RELOAD;
        end else if (poll_cnt_q != '0) begin
          poll_cnt_d = poll_cnt_q - 1'b1;
        end
      end
      READ: begin
        if (!avm.avm_waitrequest) lat_cnt_d = LAT_RELOAD;
      end
      WAIT: begin
        if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end else begin
          sample_valid = 1'b1;
          poll_cnt_d   = POLL_RELOAD;
        end
      end
      default: ;
    endcase

    // The read strobe is a flop, so it is loaded from the state being entered.
    read_d = (state_d == READ);

    // Counting on the capture edge keeps the count in step with the event pulse.
    rise_edge = sample_valid && avm.avm_readdata[0] && !shoot_level &&
                (stable_cnt == STABLE_LAST);
    count_d   = count_q + CNT_W'(rise_edge);
  end

  sample_debounce #(
    .DEBOUNCE_COUNT (DEBOUNCE_COUNT)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (avm.avm_readdata[0]),
    .level        (shoot_level),
    .rise_pulse   (shoot_event),
    .stable_cnt   (stable_cnt)
  );

  assign avm.avm_read    = read_q;
  assign avm.avm_address = PIO_DATA_ADDR;
  assign shoot_count     = count_q;
  assign unused_readdata = ^avm.avm_readdata[31:1];

endmodule

// File: tb/tb_alien_shoot_poller.sv
// tb/tb_alien_shoot_poller.sv - scoreboard bench for alien_shoot_poller with a scripted Avalon slave
module tb_alien_shoot_poller;

  localparam int CW = 4;

  typedef struct {
    int            start;
    int            stalls;
    logic          lvl;
    logic          ev;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          shoot_level;
  logic          shoot_event;
  logic [CW-1:0] shoot_count;

  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  int            next_start = 0;
  bit            stim_done = 1'b0;
  bit            pending = 1'b0;
  bit            have_cur = 1'b0;

  exp_t          exp_q[$];
  logic [31:0]   sample_q[$];
  int            stall_q[$];

  alien_shoot_poller_if bus ();

  alien_shoot_poller #(
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .avm         (bus),
    .shoot_level (shoot_level),
    .shoot_event (shoot_event),
    .shoot_count (shoot_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic add_poll(input logic [31:0] data, input int stalls,
                          input logic lvl, input logic ev, input logic [CW-1:0] cnt);
    exp_t e;
    e.start  = next_start;
    e.stalls = stalls;
    e.lvl    = lvl;
    e.ev     = ev;
    e.cnt    = cnt;
    exp_q.push_back(e);
    sample_q.push_back(data);
    stall_q.push_back(stalls);
    next_start = next_start + 10 + stalls;
  endtask

  task automatic wait_until(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, req, cyc);
    end
  endtask

  // Scripted slave: stall count and read data per accepted read come from the plan queues.
  initial begin : slave
    bit in_read;
    int stall_left;
    in_read    = 1'b0;
    stall_left = 0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.avm_read && !in_read) begin
        in_read    = 1'b1;
        stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
      end
      if (in_read) begin
        if (stall_left > 0) begin
          bus.avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          bus.avm_waitrequest = 1'b0;
          in_read = 1'b0;
          bus.avm_readdata = (sample_q.size() > 0) ? sample_q.pop_front() : 32'h0;
        end
      end else begin
        bus.avm_waitrequest = 1'b0;
      end
    end
  end

  initial begin : stimulus
    logic [31:0]   d1 [18] = '{32'h0, 32'h0, 32'h0,
                               32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                               32'h1, 32'h1, 32'h1,
                               32'h0, 32'h0, 32'h0,
                               32'h1, 32'h1, 32'h0, 32'h1, 32'h1, 32'h1};
    int            s1 [18] = '{0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic          l1 [18] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
    logic          e1 [18] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic [CW-1:0] c1 [18] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2};
    int w;
    int last;

    reset  = 1'b0;
    enable = 1'b1;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);

    // Cycle 0 is the one in which reset drops; first read is due in cycle 8.
    next_start = cyc + 8;
    for (int i = 0; i < 18; i++) add_poll(d1[i], s1[i], l1[i], e1[i], c1[i]);
    w = next_start + 1;
    add_poll(32'h1, 0, 1'b0, 1'b0, '0);
    reset = 1'b0;

    // Abort the next poll in its WAIT cycle.
    wait_until(w);
    reset = 1'b1;
    wait_until(w + 2);
    next_start = cyc + 8;
    for (int k = 1; k <= 16; k++) begin
      add_poll(32'h1, 0, 1'b0, 1'b0, CW'(k - 1));
      add_poll(32'h1, 0, 1'b0, 1'b0, CW'(k - 1));
      add_poll(32'h1, 0, 1'b1, 1'b1, CW'(k));
      add_poll(32'h0, 0, 1'b1, 1'b0, CW'(k));
      add_poll(32'h0, 0, 1'b1, 1'b0, CW'(k));
      add_poll(32'h0, 0, 1'b0, 1'b0, CW'(k));
    end
    reset = 1'b0;

    // Disable for 20 edges while idle after the last poll.
    last = next_start - 10;
    wait_until(last + 2);
    enable = 1'b0;
    wait_until(last + 22);
    enable = 1'b1;
    next_start = cyc + 8;
    add_poll(32'h0, 0, 1'b0, 1'b0, '0);
    add_poll(32'h1, 0, 1'b0, 1'b0, '0);
    stim_done = 1'b1;
  end

  initial begin : monitor
    exp_t cur;
    bit   prev_read;
    int   start_cyc;
    int   chk_cyc;
    prev_read = 1'b0;
    start_cyc = 0;
    chk_cyc   = 0;
    while (!(stim_done && exp_q.size() == 0 && !pending && !have_cur)) begin
      @(negedge clk);
      #3;
      if (cyc > 4000) begin
        chk("timeout", 1, 0);
        break;
      end
      if (reset) begin
        chk("reset_outputs", {bus.avm_read, bus.avm_address, shoot_level, shoot_event, shoot_count}, 0);
        pending   = 1'b0;
        have_cur  = 1'b0;
        prev_read = 1'b0;
      end else begin
        if (bus.avm_read && !prev_read) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_read", cyc, -1);
          end else begin
            cur       = exp_q.pop_front();
            have_cur  = 1'b1;
            start_cyc = cyc;
            chk("read_start_cycle", cyc, cur.start);
          end
        end
        if (bus.avm_read) chk("read_address", bus.avm_address, 0);
        if (bus.avm_read && !bus.avm_waitrequest && have_cur) begin
          chk("read_length", cyc - start_cyc + 1, cur.stalls + 1);
          pending = 1'b1;
          chk_cyc = cyc + 2;
        end
        if (pending && cyc == chk_cyc) begin
          chk("shoot_level", shoot_level, cur.lvl);
          chk("shoot_event", shoot_event, cur.ev);
          chk("shoot_count", shoot_count, cur.cnt);
          pending  = 1'b0;
          have_cur = 1'b0;
        end else begin
          chk("event_quiet", shoot_event, 0);
        end
        prev_read = bus.avm_read;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
